k2red_sched: RTL and testbench
==============================

K2RED_SCHED -- requirements
Module: k2red_sched

Interface
REQ-001 Parameters SHALL be:
- LOGQ, default 32, operand/result width.
- LOGQH, default 15, width of qH.
- LOGL, default 4, width of L1/L2/L3.
- NREQ, default 4, requester count (power of two, 2..8).
- LAT, default 5, fixed datapath latency in cycles (3+2*FF_SHF).
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant (one-hot or zero).
- req_c  in  NREQ*2*LOGQ  per-requester operand C, slot i at bits [i*2*LOGQ +: 2*LOGQ].
- cfg_we  in  1  config write strobe.
- cfg_id  in  log2(NREQ)  requester whose config is written.
- cfg_qh  in  LOGQH  qH for that requester.
- cfg_l  in  3*LOGL  {L3,L2,L1} for that requester.
- flush_req  in  1  level request to stop issuing and drain.
- flush_done  out  1  high while drained and halted.
- red_C, red_qH, red_L1, red_L2, red_L3  out  2*LOGQ/LOGQH/LOGL x3  operand bus to the external k2red_shift datapath.
- red_T  in  LOGQ  datapath result.
- rsp_valid  out  1  result valid.
- rsp_id  out  log2(NREQ)  owner of result.
- rsp_t  out  LOGQ  result (equals red_T).

Function
REQ-003 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high per cycle.
REQ-004 req_ready SHALL be combinational from req_valid, the round-robin pointer and the FSM state; it SHALL be zero when no requester is valid or the state is not RUN.
REQ-005 Arbitration SHALL be round-robin: search starts at pointer p; after a grant to i, p SHALL become (i+1) mod NREQ; p SHALL be unchanged when there is no grant.
REQ-006 In a grant cycle, red_C SHALL equal req_c of the winner, and red_qH/red_L1..L3 SHALL equal that requester's config registers; in other cycles red_* SHALL be zero.
REQ-007 Config registers SHALL be written at the clock edge when cfg_we is high; a grant to the same requester in that cycle SHALL use the old values.
REQ-008 A LAT-deep valid/id shift register SHALL track issues; rsp_valid and rsp_id SHALL equal that register's output exactly LAT cycles after the grant, and rsp_t SHALL be red_T passed through combinationally.
REQ-009 Responses SHALL be in issue order, one per cycle maximum, with no backpressure.
REQ-010 The FSM SHALL have states RUN, DRAIN and HALT.
- RUN: flush_req high SHALL go to DRAIN with no grant in that cycle.
- DRAIN: no grants; when the tracker is empty, SHALL go to HALT.
- HALT: flush_done high; when flush_req is low, SHALL go to RUN.
REQ-011 flush_done SHALL be high only in HALT; a flush with an empty tracker SHALL reach HALT in 2 cycles.

Reset
REQ-012 When rst is high at a clock edge, the following SHALL occur:
- FSM to RUN; p to 0.
- Tracker cleared; in-flight results are discarded, with rsp_valid low from the next cycle.
- All config registers to zero (qH=0, L=0).
- flush_done low.
REQ-013 req_ready SHALL be zero in any cycle where rst is high.

Configuration
REQ-014 Macro K2RED_SCHED_STATS_EN:
- When defined: adds inputs stat_id (log2(NREQ)) and stat_clr (1), and output stat_cnt (16).
- Per requester, a 16-bit saturating grant counter SHALL be kept, cleared by rst or stat_clr (clear has priority over increment).
- stat_cnt SHALL be the registered count of stat_id, available one cycle after it is presented.
- When undefined: ports and counters SHALL be absent, with identical other behaviour.

Verification
REQ-015 The bench SHALL cover:
- Single issue: cfg id0 qH=16394, L1=2, L2=1, L3=3; req0 C=2500883870215315764 with k2red_shift (LAT=5) attached -> rsp_valid 5 cycles later, rsp_id=0, rsp_t=1965696994.
- All four requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order, 5 cycles delayed.
- cfg_we on id1 in the same cycle as req1 is granted -> red_qH carries the old qH; the next grant carries the new qH.
- Three issues, then flush_req raised -> no further grants; flush_done rises once the last rsp_valid has drained; dropping flush_req resumes RUN.
- rst asserted 2 cycles after an issue -> no rsp_valid appears; p=0, so the next grant goes to req0 when all are valid.
- STATS_EN: 70000 grants to req2 -> stat_cnt=65535; stat_clr -> 0.

Source files
------------

// File: rtl/k2red_sched.sv
// Round-robin issue scheduler feeding an external fixed-latency K2-RED datapath, with flush/drain control.
// Optional per-requester saturating grant counters are enabled by defining K2RED_SCHED_STATS_EN.
module k2red_sched #(
  parameter int LOGQ  = 32,
  parameter int LOGQH = 15,
  parameter int LOGL  = 4,
  parameter int NREQ  = 4,
  parameter int LAT   = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*2*LOGQ-1:0]     req_c,
  input  logic                       cfg_we,
  input  logic [$clog2(NREQ)-1:0]    cfg_id,
  input  logic [LOGQH-1:0]           cfg_qh,
  input  logic [3*LOGL-1:0]          cfg_l,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic [2*LOGQ-1:0]          red_C,
  output logic [LOGQH-1:0]           red_qH,
  output logic [LOGL-1:0]            red_L1,
  output logic [LOGL-1:0]            red_L2,
  output logic [LOGL-1:0]            red_L3,
  input  logic [LOGQ-1:0]            red_T,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [LOGQ-1:0]            rsp_t
`ifdef K2RED_SCHED_STATS_EN
  ,
  input  logic [$clog2(NREQ)-1:0]    stat_id,
  input  logic                       stat_clr,
  output logic [15:0]                stat_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = 2 * LOGQ;
  localparam int LW  = 3 * LOGL;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t           state_q;
  logic             flush_done_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [LOGQH-1:0] cfg_qh_q [NREQ];
  logic [LOGQH-1:0] cfg_qh_d [NREQ];
  logic [LW-1:0]    cfg_l_q  [NREQ];
  logic [LW-1:0]    cfg_l_d  [NREQ];
  logic [LAT-1:0]   trk_vld_q, trk_vld_d;
  logic [IDW-1:0]   trk_id_q [LAT];
  logic [IDW-1:0]   trk_id_d [LAT];

  logic             gnt_found;
  logic             gnt_en;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;
  logic [CW-1:0]    win_c;
  logic [LOGQH-1:0] win_qh;
  logic [LW-1:0]    win_l;
  logic             trk_empty;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + IDW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_en    = gnt_found && (state_q == RUN) && !flush_req && !rst;
  assign req_ready = gnt_en ? (NREQ'(1) << gnt_idx) : '0;
  assign ptr_d     = gnt_en ? gnt_idx + IDW'(1) : ptr_q;

  always_comb begin
    win_c  = '0;
    win_qh = '0;
    win_l  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        win_c  = req_c[i*CW +: CW];
        win_qh = cfg_qh_q[i];
        win_l  = cfg_l_q[i];
      end
    end
  end

  assign red_C  = gnt_en ? win_c : '0;
  assign red_qH = gnt_en ? win_qh : '0;
  assign red_L1 = gnt_en ? win_l[0*LOGL +: LOGL] : '0;
  assign red_L2 = gnt_en ? win_l[1*LOGL +: LOGL] : '0;
  assign red_L3 = gnt_en ? win_l[2*LOGL +: LOGL] : '0;

  // Config bank: the grant mux above reads the _q side, so a same-cycle write is seen next grant.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cfg_qh_d[i] = cfg_qh_q[i];
      cfg_l_d[i]  = cfg_l_q[i];
      if (cfg_we && (cfg_id == IDW'(i))) begin
        cfg_qh_d[i] = cfg_qh;
        cfg_l_d[i]  = cfg_l;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cfg_qh_q[i] <= '0;
        cfg_l_q[i]  <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < NREQ; i++) begin
        cfg_qh_q[i] <= cfg_qh_d[i];
        cfg_l_q[i]  <= cfg_l_d[i];
      end
    end
  end

  // Issue tracker: mirrors the datapath latency so the owner id lines up with red_T.
  always_comb begin
    trk_vld_d[0] = gnt_en;
    trk_id_d[0]  = gnt_idx;
    for (int i = 1; i < LAT; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_id_d[i]  = trk_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld_q <= '0;
    end else begin
      trk_vld_q <= trk_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) begin
      trk_id_q[i] <= trk_id_d[i];
    end
  end

  assign trk_empty = ~|trk_vld_q;
  assign rsp_valid = trk_vld_q[LAT-1];
  assign rsp_id    = trk_id_q[LAT-1];
  assign rsp_t     = red_T;

  // Flush control: DRAIN waits until the last in-flight result has been presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (trk_empty) begin
            state_q      <= HALT;
            flush_done_q <= 1'b1;
          end
        end
        HALT: begin
          if (!flush_req) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RUN;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush_done = flush_done_q;

`ifdef K2RED_SCHED_STATS_EN
  logic [15:0] stat_q [NREQ];
  logic [15:0] stat_d [NREQ];
  logic [15:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (gnt_en && (gnt_idx == IDW'(i)) && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
    stat_cnt_d = stat_q[stat_id];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt_q <= '0;
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
      for (int i = 0; i < NREQ; i++) stat_q[i] <= stat_d[i];
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_k2red_sched.sv
// Randomized and directed bench for k2red_sched against a queue-based reference model and a stand-in datapath.
module tb_k2red_sched;
  localparam int LOGQ  = 32;
  localparam int LOGQH = 15;
  localparam int LOGL  = 4;
  localparam int NREQ  = 4;
  localparam int LAT   = 5;
  localparam int IDW   = 2;
  localparam logic [63:0] KAT_C = 64'd2500883870215315764;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*2*LOGQ-1:0] req_c = '0;
  logic                   cfg_we = 1'b0;
  logic [IDW-1:0]         cfg_id = '0;
  logic [LOGQH-1:0]       cfg_qh = '0;
  logic [3*LOGL-1:0]      cfg_l = '0;
  logic                   flush_req = 1'b0;
  logic                   flush_done;
  logic [2*LOGQ-1:0]      red_C;
  logic [LOGQH-1:0]       red_qH;
  logic [LOGL-1:0]        red_L1, red_L2, red_L3;
  logic [LOGQ-1:0]        red_T;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [LOGQ-1:0]        rsp_t;
`ifdef K2RED_SCHED_STATS_EN
  logic [IDW-1:0]         stat_id = '0;
  logic                   stat_clr = 1'b0;
  logic [15:0]            stat_cnt;
`endif

  always #5 clk = ~clk;

  k2red_sched #(.LOGQ(LOGQ), .LOGQH(LOGQH), .LOGL(LOGL), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_c(req_c),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_qh(cfg_qh), .cfg_l(cfg_l),
    .flush_req(flush_req), .flush_done(flush_done),
    .red_C(red_C), .red_qH(red_qH), .red_L1(red_L1), .red_L2(red_L2), .red_L3(red_L3),
    .red_T(red_T),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_t(rsp_t)
`ifdef K2RED_SCHED_STATS_EN
    , .stat_id(stat_id), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stand-in for k2red_shift: known answer for the reference vector, otherwise a mixing function.
  function automatic logic [31:0] dp_f(input logic [63:0] c, input logic [14:0] qh, input logic [11:0] l);
    if (c == KAT_C && qh == 15'd16394 && l == {4'd3, 4'd1, 4'd2}) return 32'd1965696994;
    return c[31:0] ^ {c[47:32], c[63:48]} ^ {qh, 5'd0, l};
  endfunction

  logic [LOGQ-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_f(red_C, red_qH, {red_L3, red_L2, red_L1});
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign red_T = dp_pipe[LAT-1];

  // Reference model, evaluated once per cycle on the falling edge.
  typedef struct {
    int          id;
    longint      due;
    logic [31:0] t;
  } exp_t;

  exp_t             expq[$];
  int               mstate = 0;   // 0 RUN, 1 DRAIN, 2 HALT
  int               mp = 0;
  logic [LOGQH-1:0] mqh [NREQ];
  logic [11:0]      ml  [NREQ];
  longint           cyc = 0;

  always @(negedge clk) begin
    int              win;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    logic [63:0]     wc;
    bit              empty;
    exp_t            e;
    cyc++;
    win = -1;
    if (!rst && mstate == 0 && !flush_req) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (mp + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    exp_rdy = (win >= 0) ? NREQ'(1 << win) : '0;
    chk("ready", 64'(req_ready), 64'(exp_rdy));
    if (win >= 0) begin
      wc = req_c[win*64 +: 64];
      chk("red_C", red_C, wc);
      chk("red_qH", 64'(red_qH), 64'(mqh[win]));
      chk("red_L", 64'({red_L3, red_L2, red_L1}), 64'(ml[win]));
    end else begin
      chk("red_idle", 64'({red_qH, red_L3, red_L2, red_L1}) | red_C, 64'd0);
    end
    chk("flush_done", 64'(flush_done), 64'(mstate == 2));
    empty = (expq.size() == 0);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(expq[0].id));
      chk("rsp_t", 64'(rsp_t), 64'(expq[0].t));
      void'(expq.pop_front());
    end else begin
      chk("rsp_valid", 64'(rsp_valid), 64'd0);
    end
    if (rst) begin
      mstate = 0;
      mp = 0;
      expq.delete();
      for (int i = 0; i < NREQ; i++) begin
        mqh[i] = '0;
        ml[i]  = '0;
      end
    end else begin
      if (win >= 0) begin
        e.id  = win;
        e.due = cyc + LAT;
        e.t   = dp_f(req_c[win*64 +: 64], mqh[win], ml[win]);
        expq.push_back(e);
        mp = (win + 1) % NREQ;
      end
      if (cfg_we) begin
        mqh[cfg_id] = cfg_qh;
        ml[cfg_id]  = cfg_l;
      end
      case (mstate)
        0: if (flush_req) mstate = 1;
        1: if (empty) mstate = 2;
        default: if (!flush_req) mstate = 0;
      endcase
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int done_k;
    int last_rsp;
    for (int i = 0; i < NREQ; i++) begin
      mqh[i] = '0;
      ml[i]  = '0;
    end
    repeat (3) nxt();
    rst = 1'b0;

    // Single issue with the reference vector
    cfg_we = 1'b1; cfg_id = 2'd0; cfg_qh = 15'd16394; cfg_l = {4'd3, 4'd1, 4'd2};
    nxt();
    cfg_we = 1'b0;
    req_valid = 4'b0001;
    req_c[63:0] = KAT_C;
    @(negedge clk);
    chk("kat_ready", 64'(req_ready), 64'd1);
    nxt();
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        chk("kat_early", 64'(rsp_valid), 64'd0);
      end else begin
        chk("kat_valid", 64'(rsp_valid), 64'd1);
        chk("kat_id", 64'(rsp_id), 64'd0);
        chk("kat_t", 64'(rsp_t), 64'd1965696994);
      end
      nxt();
    end

    // All four valid for 8 cycles from pointer 0
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k < 8) chk("rr_order", 64'(req_ready), 64'(1 << (k % 4)));
      if (k >= LAT) begin
        chk("rr_rsp_v", 64'(rsp_valid), 64'd1);
        chk("rr_rsp_id", 64'(rsp_id), 64'((k - LAT) % 4));
      end
      nxt();
      if (k == 7) req_valid = '0;
    end

    // Config write colliding with a grant to the same requester
    req_valid = 4'b0010;
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_qh = 15'd777; cfg_l = 12'h5a3;
    @(negedge clk);
    chk("cfg_old_qh", 64'(red_qH), 64'd0);
    nxt();
    cfg_we = 1'b0;
    @(negedge clk);
    chk("cfg_new_qh", 64'(red_qH), 64'd777);
    chk("cfg_new_L1", 64'(red_L1), 64'h3);
    nxt();

    // Three issues, then flush and drain
    req_valid = 4'hF;
    repeat (3) nxt();
    flush_req = 1'b1;
    done_k = -1;
    last_rsp = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("flush_nogrant", 64'(req_ready), 64'd0);
      if (rsp_valid) last_rsp = k;
      if (flush_done && done_k < 0) done_k = k;
      if (done_k >= 0) break;
      nxt();
    end
    if (done_k < 0) chk("flush_timeout", 64'd0, 64'd1);
    else chk("flush_lat", 64'(done_k - last_rsp), 64'd2);
    nxt();
    flush_req = 1'b0;
    @(negedge clk);
    chk("halt_nogrant", 64'(req_ready), 64'd0);
    nxt();
    @(negedge clk);
    chk("resume", 64'(req_ready), 64'b0010);
    nxt();
    req_valid = '0;
    repeat (8) nxt();

    // Reset two cycles after an issue
    req_valid = 4'b0100;
    nxt();
    req_valid = '0;
    nxt();
    rst = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    nxt();
    rst = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) chk("rst_ptr0", 64'(req_ready), 64'd1);
      chk("rst_norsp", 64'(rsp_valid), 64'd0);
      nxt();
    end
    req_valid = '0;
    repeat (8) nxt();

    // Flush with an empty tracker
    flush_req = 1'b1;
    @(negedge clk);
    chk("fe_c0", 64'(flush_done), 64'd0);
    nxt();
    @(negedge clk);
    chk("fe_c1", 64'(flush_done), 64'd0);
    nxt();
    @(negedge clk);
    chk("fe_c2", 64'(flush_done), 64'd1);
    flush_req = 1'b0;
    repeat (2) nxt();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) req_c[i*64 +: 64] = {$urandom, $urandom};
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_id = IDW'($urandom);
      cfg_qh = LOGQH'($urandom);
      cfg_l  = 12'($urandom);
      if ($urandom_range(0, 30) == 0) flush_req = ~flush_req;
      rst = ($urandom_range(0, 120) == 0);
      nxt();
    end
    req_valid = '0; cfg_we = 1'b0; flush_req = 1'b0; rst = 1'b0;
    repeat (12) nxt();

`ifdef K2RED_SCHED_STATS_EN
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    req_valid = 4'b0010;
    repeat (3) nxt();
    req_valid = '0;
    stat_id = 2'd1;
    repeat (2) nxt();
    @(negedge clk);
    chk("stat_small", 64'(stat_cnt), 64'd3);
    req_valid = 4'b0100;
    repeat (70000) nxt();
    req_valid = '0;
    stat_id = 2'd2;
    repeat (2) nxt();
    @(negedge clk);
    chk("stat_sat", 64'(stat_cnt), 64'd65535);
    nxt();
    stat_clr = 1'b1;
    nxt();
    stat_clr = 1'b0;
    repeat (2) nxt();
    @(negedge clk);
    chk("stat_clr", 64'(stat_cnt), 64'd0);
    repeat (8) nxt();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
